// File: rtl/forwarder_mc_if.sv
// Request, broadcast and result signals of the multi-channel forwarder.
// master = producer/consumer side, slave = forwarder side.
interface forwarder_mc_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned NUM_BCAST = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [TAG_W-1:0]            in_target;
  logic [DATA_W-1:0]           in_val;
  logic [TAG_W-1:0]            in_tag;
  logic [NUM_BCAST-1:0]        bc_valid;
  logic [NUM_BCAST*TAG_W-1:0]  bc_tag;
  logic [NUM_BCAST*DATA_W-1:0] bc_val;
  logic                        out_valid;
  logic                        out_ready;
  logic [TAG_W-1:0]            out_target;
  logic [DATA_W-1:0]           out_result;
  logic [CNT_W-1:0]            count;

  modport master (
    output in_valid, in_target, in_val, in_tag, bc_valid, bc_tag, bc_val, out_ready,
    input  in_ready, out_valid, out_target, out_result, count
  );

  modport slave (
    input  in_valid, in_target, in_val, in_tag, bc_valid, bc_tag, bc_val, out_ready,
    output in_ready, out_valid, out_target, out_result, count
  );
endinterface

// File: rtl/forwarder_mc.sv
// Forwarding buffer: holds tagged requests, captures values from broadcast channels
// (including same-cycle bypass) and issues ready entries oldest-first to an output register.
module forwarder_mc #(
  parameter int unsigned     DEPTH       = 8,
  parameter int unsigned     DATA_W      = 32,
  parameter int unsigned     TAG_W       = 5,
  parameter int unsigned     NUM_BCAST   = 2,
  parameter logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}}
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  forwarder_mc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  ent_v;
  logic [DEPTH-1:0]  ent_rdy;
  logic [TAG_W-1:0]  ent_tgt [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];
  logic [DATA_W-1:0] ent_val [DEPTH];
  logic [DEPTH-1:0]  older   [DEPTH];  // older[i][j]: entry i was inserted before entry j
  logic [CNT_W-1:0]  cnt_q;
  logic              out_v_q;
  logic [TAG_W-1:0]  out_tgt_q;
  logic [DATA_W-1:0] out_res_q;

  logic [TAG_W-1:0]  bc_tag_a [NUM_BCAST];
  logic [DATA_W-1:0] bc_val_a [NUM_BCAST];
  logic [NUM_BCAST-1:0] bc_ok;

  logic              ins_acc;
  logic              ins_wr;
  logic [IDX_W-1:0]  ins_idx;
  logic              ins_rdy;
  logic [DATA_W-1:0] ins_v;
  logic [DEPTH-1:0]  wake;
  logic [DATA_W-1:0] wake_val [DEPTH];
  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  blocked;
  logic [IDX_W-1:0]  iss_idx;
  logic              iss_any;
  logic              load;
  logic              iss;

  // Unpack broadcast channels; an invalid-tag broadcast never matches
  for (genvar k = 0; k < NUM_BCAST; k++) begin : g_bc
    assign bc_tag_a[k] = bus.bc_tag[k*TAG_W +: TAG_W];
    assign bc_val_a[k] = bus.bc_val[k*DATA_W +: DATA_W];
    assign bc_ok[k]    = bus.bc_valid[k] && (bc_tag_a[k] != TAG_INVALID);
  end

  assign bus.in_ready = !rst && (cnt_q < CNT_W'(DEPTH));
  assign ins_acc      = bus.in_valid && bus.in_ready;
  assign ins_wr       = ins_acc && (bus.in_target != TAG_INVALID);

  // Lowest free slot; one always exists whenever in_ready is high
  always_comb begin
    ins_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_v[i]) ins_idx = IDX_W'(i);
    end
  end

  // Readiness of the incoming request, lowest matching channel wins
  always_comb begin
    ins_rdy = (bus.in_tag == TAG_INVALID);
    ins_v   = bus.in_val;
    for (int k = NUM_BCAST - 1; k >= 0; k--) begin
      if (bc_ok[k] && (bc_tag_a[k] == bus.in_tag)) begin
        ins_rdy = 1'b1;
        ins_v   = bc_val_a[k];
      end
    end
  end

  // Wakeup of waiting entries, lowest matching channel wins
  always_comb begin
    wake = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_val[i] = '0;
      for (int k = NUM_BCAST - 1; k >= 0; k--) begin
        if (ent_v[i] && !ent_rdy[i] && bc_ok[k] && (bc_tag_a[k] == ent_tag[i])) begin
          wake[i]     = 1'b1;
          wake_val[i] = bc_val_a[k];
        end
      end
    end
  end

  // Oldest eligible entry: eligible with no older eligible entry
  always_comb begin
    elig    = ent_v & ent_rdy;
    blocked = '0;
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !blocked[i]) iss_idx = IDX_W'(i);
    end
  end

  assign iss_any = |elig;
  assign load    = !out_v_q || bus.out_ready;
  assign iss     = load && iss_any;

  // Control state: occupancy, readiness and output register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_v     <= '0;
      ent_rdy   <= '0;
      cnt_q     <= '0;
      out_v_q   <= 1'b0;
      out_tgt_q <= TAG_INVALID;
      out_res_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake[i]) ent_rdy[i] <= 1'b1;
      end
      if (iss) ent_v[iss_idx] <= 1'b0;
      if (ins_wr) begin
        ent_v[ins_idx]   <= 1'b1;
        ent_rdy[ins_idx] <= ins_rdy;
      end
      if (load) begin
        out_v_q <= iss_any;
        if (iss_any) begin
          out_tgt_q <= ent_tgt[iss_idx];
          out_res_q <= ent_val[iss_idx];
        end
      end
      cnt_q <= cnt_q + CNT_W'(ins_wr) - CNT_W'(iss);
    end
  end

  // Payload and age state; only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wake[i]) ent_val[i] <= wake_val[i];
    end
    if (ins_wr) begin
      ent_tgt[ins_idx] <= bus.in_target;
      ent_tag[ins_idx] <= bus.in_tag;
      ent_val[ins_idx] <= ins_v;
      for (int j = 0; j < DEPTH; j++) begin
        older[j][ins_idx] <= 1'b1;
        older[ins_idx][j] <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_v_q;
  assign bus.out_target = out_tgt_q;
  assign bus.out_result = out_res_q;
  assign bus.count      = cnt_q;
endmodule

// File: tb/tb_forwarder_mc.sv
// Bench for forwarder_mc: directed vectors, an in-order queue model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_forwarder_mc;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned NUM_BCAST = 2;
  localparam logic [TAG_W-1:0] INV  = 5'h1f;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  forwarder_mc_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BCAST(NUM_BCAST)) bus ();

  forwarder_mc #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BCAST(NUM_BCAST)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Model: queue in insertion order, output register as three scalars
  typedef struct {
    logic [TAG_W-1:0]  tgt;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    bit                rdy;
  } m_ent_t;

  m_ent_t            mq[$];
  bit                m_ov = 1'b0;
  logic [TAG_W-1:0]  m_ot = INV;
  logic [DATA_W-1:0] m_or = '0;

  function automatic int first_bc(input logic [TAG_W-1:0] t);
    for (int k = 0; k < NUM_BCAST; k++) begin
      if (bus.bc_valid[k] && t != INV && bus.bc_tag[k*TAG_W +: TAG_W] == t) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit     acc;
    int     hit;
    int     k;
    m_ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_ov = 1'b0;
      m_ot = INV;
      m_or = '0;
    end else begin
      acc = bus.in_valid && (mq.size() < DEPTH);
      if (!m_ov || bus.out_ready) begin
        hit = -1;
        foreach (mq[i]) if (hit < 0 && mq[i].rdy) hit = i;
        m_ov = (hit >= 0);
        if (hit >= 0) begin
          m_ot = mq[hit].tgt;
          m_or = mq[hit].val;
          mq.delete(hit);
        end
      end
      foreach (mq[i]) begin
        if (!mq[i].rdy) begin
          k = first_bc(mq[i].tag);
          if (k >= 0) begin
            mq[i].rdy = 1'b1;
            mq[i].val = bus.bc_val[k*DATA_W +: DATA_W];
          end
        end
      end
      if (acc && bus.in_target != INV) begin
        e.tgt = bus.in_target;
        e.tag = bus.in_tag;
        e.val = bus.in_val;
        e.rdy = (bus.in_tag == INV);
        if (!e.rdy) begin
          k = first_bc(e.tag);
          if (k >= 0) begin
            e.rdy = 1'b1;
            e.val = bus.bc_val[k*DATA_W +: DATA_W];
          end
        end
        mq.push_back(e);
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_check();
    cmp("in_ready", 64'(bus.in_ready), 64'(!rst && (mq.size() < DEPTH)));
    cmp("count", 64'(bus.count), 64'(mq.size()));
    cmp("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov) begin
      cmp("out_target", 64'(bus.out_target), 64'(m_ot));
      cmp("out_result", 64'(bus.out_result), 64'(m_or));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.bc_valid = '0;
    flush        = 1'b0;
  endtask

  task automatic ins(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] v);
    bus.in_valid  = 1'b1;
    bus.in_target = t;
    bus.in_tag    = tg;
    bus.in_val    = v;
  endtask

  task automatic bc(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    bus.bc_valid[k]                 = 1'b1;
    bus.bc_tag[k*TAG_W +: TAG_W]    = t;
    bus.bc_val[k*DATA_W +: DATA_W]  = v;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_target = '0;
    bus.in_tag = INV;
    bus.in_val = '0;
    bus.bc_valid = '0;
    bus.bc_tag = '0;
    bus.bc_val = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    cmp("rst_in_ready", 64'(bus.in_ready), 64'(0));
    cmp("rst_out_target", 64'(bus.out_target), 64'(INV));
    cmp("rst_out_result", 64'(bus.out_result), 64'(0));
    rst = 1'b0;

    // Known value: appears one posedge after the insert posedge
    ins(5'd3, INV, 32'hAA); tick(); idle();
    cmp("t1_count_after_insert", 64'(bus.count), 64'(1));
    cmp("t1_no_early_valid", 64'(bus.out_valid), 64'(0));
    tick();
    cmp("t1_out_target", 64'(bus.out_target), 64'(3));
    cmp("t1_out_result", 64'(bus.out_result), 64'(32'hAA));
    cmp("t1_count_zero", 64'(bus.count), 64'(0));

    // Wait on tag 7, wake on channel 0
    ins(5'd4, 5'd7, 32'h0); tick(); idle();
    tick();
    cmp("t2_waiting_no_out", 64'(bus.out_valid), 64'(0));
    bc(0, 5'd7, 32'h1234); tick(); idle();
    cmp("t2_wake_not_same_cycle", 64'(bus.out_valid), 64'(0));
    tick();
    cmp("t2_out_target", 64'(bus.out_target), 64'(4));
    cmp("t2_out_result", 64'(bus.out_result), 64'(32'h1234));

    // Same-cycle bypass, both channels match: channel 0 wins
    ins(5'd5, 5'd9, 32'h0); bc(0, 5'd9, 32'h11); bc(1, 5'd9, 32'h22); tick(); idle();
    tick();
    cmp("t3_out_target", 64'(bus.out_target), 64'(5));
    cmp("t3_out_result", 64'(bus.out_result), 64'(32'h11));

    // Fill while stalled; output held, then drain in order
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      ins(5'(t), INV, 32'(t * 16)); tick();
      cmp("t4_held_target", 64'(bus.out_target), 64'(5));
    end
    idle();
    cmp("t4_full_count", 64'(bus.count), 64'(8));
    cmp("t4_full_in_ready", 64'(bus.in_ready), 64'(0));
    ins(5'd9, INV, 32'h99); tick(); idle();
    cmp("t4_ninth_rejected", 64'(bus.count), 64'(8));
    bus.out_ready = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      cmp("t4_drain_target", 64'(bus.out_target), 64'(t));
      cmp("t4_drain_result", 64'(bus.out_result), 64'(t * 16));
    end
    tick();
    cmp("t4_drained", 64'(bus.out_valid), 64'(0));

    // Ready younger entry overtakes waiting older one
    ins(5'd1, 5'd6, 32'h0); tick();
    ins(5'd2, INV, 32'h22); tick(); idle();
    tick();
    cmp("t5_younger_first", 64'(bus.out_target), 64'(2));
    bc(0, 5'd6, 32'h66); tick(); idle();
    cmp("t5_gap", 64'(bus.out_valid), 64'(0));
    tick();
    cmp("t5_older_target", 64'(bus.out_target), 64'(1));
    cmp("t5_older_result", 64'(bus.out_result), 64'(32'h66));
    ins(5'd10, INV, 32'hA0); tick();
    ins(5'd11, INV, 32'hB0); tick(); idle();
    cmp("t5_order_a", 64'(bus.out_target), 64'(10));
    tick();
    cmp("t5_order_b", 64'(bus.out_target), 64'(11));

    // Flush with an insert in the same cycle
    bus.out_ready = 1'b0;
    for (int t = 12; t <= 14; t++) begin
      ins(5'(t), INV, 32'(t)); tick();
    end
    idle();
    cmp("t6_pre_count", 64'(bus.count), 64'(3));
    cmp("t6_pre_valid", 64'(bus.out_valid), 64'(1));
    flush = 1'b1; ins(5'd20, INV, 32'h20); tick(); idle();
    cmp("t6_flush_count", 64'(bus.count), 64'(0));
    cmp("t6_flush_valid", 64'(bus.out_valid), 64'(0));
    cmp("t6_flush_target", 64'(bus.out_target), 64'(INV));
    tick();
    cmp("t6_insert_dropped", 64'(bus.count), 64'(0));

    // Reset mid-stall
    for (int t = 1; t <= 4; t++) begin
      ins(5'(t), INV, 32'(t)); tick();
    end
    idle();
    cmp("t6_stall_count", 64'(bus.count), 64'(3));
    rst = 1'b1; ins(5'd21, INV, 32'h21); tick(); idle();
    cmp("t6_rst_in_ready", 64'(bus.in_ready), 64'(0));
    cmp("t6_rst_count", 64'(bus.count), 64'(0));
    cmp("t6_rst_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0; tick();
    cmp("t6_rst_after", 64'(bus.count), 64'(0));

    // Mixed traffic: stalls, both channels, invalid-tag broadcasts, discarded inserts
    for (int i = 0; i < 48; i++) begin
      idle();
      bus.out_ready = (i % 4 != 3);
      if (i % 6 != 5) ins(5'(i % 32), (i % 3 == 0) ? INV : 5'((i % 7) + 1), 32'(i * 257));
      if (i % 2 == 0) bc(0, 5'(((i + 2) % 7) + 1), 32'(32'hC000 + i));
      if (i % 3 == 1) bc(1, (i % 5 == 0) ? INV : 5'(((i + 5) % 7) + 1), 32'(32'hD000 + i));
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      bc(0, 5'(i), 32'(32'hE000 + i)); tick(); idle();
    end
    for (int i = 0; i < 12; i++) tick();
    cmp("mix_drained_count", 64'(bus.count), 64'(0));
    cmp("mix_drained_valid", 64'(bus.out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
